subneg_mem_responder: RTL and testbench
=======================================

# subneg_mem_responder

- Memory-side responder for the SUBNEG core's external SRAM bus: it plays the address latch, the SRAM and the output latch in a single block.
- Same-clock address-latch / OE / WE / output-strobe protocol the core initiates; used as the on-chip program/data store and as the bench-side memory model.
- Holds a 2^ADDR_W × 8 register memory, preloaded through a host load port.
- Returns read data combinationally while OE is asserted; commits writes on WE falling edges.
- Captures output-port values on rising edges of the output strobe.

## Interface
- ADDR_W, 5, memory address width; depth 2^ADDR_W bytes; legal 1..8.
- clk  in  1  system clock, shared with the initiating core.
- rst_n  in  1  asynchronous, active-low reset.
- bus_latch_clk  in  1  address latch strobe, rising edge captures bus_data_in as address.
- bus_oe_n  in  1  read enable, active low.
- bus_we_n  in  1  write enable, active low; falling edge commits.
- bus_out_clk  in  1  output latch strobe, rising edge captures bus_data_in.
- bus_data_in  in  8  bus value driven by the initiator.
- bus_data_out  out  8  read data.
- bus_data_oe  out  1  high while the responder drives the bus.
- ld_en  in  1  host preload strobe; owns the memory while high.
- ld_addr  in  8  preload address.
- ld_data  in  8  preload data.
- out_q  out  8  last captured output-port value.
- out_valid  out  1  one-cycle pulse on each capture.
- bus_err  out  1  sticky protocol error flag.
- state_q  out  2  FSM state, for debug.

## Operation
- Edge detection:
  - Registered copies latch_d, oe_n_d, we_n_d and out_clk_d.
  - Reset values are 0, 1, 1 and 0 respectively.
- FSM states:
  - IDLE=0, ADDR=1, READ=2, WRITE=3.
  - IDLE→ADDR on a latch rising edge.
  - ADDR→READ when bus_oe_n=0.
  - ADDR→WRITE on a we_n falling edge.
  - READ→ADDR when oe_n returns high.
  - WRITE→ADDR when we_n returns high.
  - Any state→ADDR on a new latch rising edge.
  - ld_en=1 forces IDLE.
- Address latch: on a latch rising edge, addr_q ← bus_data_in (8 bits, full value kept).
- Read path:
  - bus_data_oe = ~bus_oe_n & ~ld_en, combinational.
  - bus_data_out = mem[addr_q] when addr_q < 2^ADDR_W, else 0x00.
- Write: a we_n falling edge writes mem[addr_q] ← bus_data_in. Out-of-range addresses are ignored.
- Output port: an out_clk rising edge sets out_q ← bus_data_in and pulses out_valid.
- Preload: while ld_en=1, each cycle mem[ld_addr[ADDR_W-1:0]] ← ld_data; bus strobes are ignored.
- Reset:
  - Memory and addr_q clear to 0x00; out_q=0x00; out_valid=0; bus_err=0; state IDLE.
  - bus_data_oe follows bus_oe_n and ld_en combinationally: 0 when bus_oe_n=1 or ld_en=1 during reset.

## Timing
- Strobes are sampled on clk; all edges are detected one cycle after the initiator registers them.
- Latch rising edge visible at edge N → addr_q valid after edge N.
- Read data is combinational from addr_q and bus_oe_n. Data is valid in the same cycle OE is seen low, so the initiator samples it on the following edge.
- Write commits at the edge where we_n=0 and we_n_d=1. WE held low for several cycles produces exactly one write.
- Simultaneous events:
  - Latch edge and WE fall in the same cycle: the write uses the old addr_q.
  - ld_en and a bus write in the same cycle: the load wins and the bus write is dropped.
  - out_clk rising and a write in the same cycle: both are performed.
- Reset mid-access aborts asynchronously; the next cycle is IDLE with the edge registers at their reset values.

## Configuration
- RESP_ERR_CHECK_EN defined:
  - bus_err sets when bus_oe_n=0 and bus_we_n=0 in the same sampled cycle.
  - bus_err also sets on an OE or WE assertion in IDLE (no address latched since reset or load).
  - Cleared only by reset.
- Not defined: bus_err is tied 0 and the checks are absent.

## Test plan
- Preload mem[3]=0x5A via ld_en; latch address 0x03, drop OE → bus_data_oe=1, bus_data_out=0x5A in that cycle; the FSM enters READ.
- Latch 0x07, hold data 0x21, pull WE low for 3 cycles → mem[7]=0x21 after a single write; a later read of 0x07 returns 0x21.
- Latch 0x40 with ADDR_W=5; read → 0x00. Write 0x99 → memory unchanged (mem[0] stays its old value).
- Data 0xC3 with an out_clk rising edge → out_q=0xC3; out_valid high for exactly 1 cycle.
- With RESP_ERR_CHECK_EN: OE and WE low together → bus_err=1 and stays 1 until rst_n=0. Without the macro: bus_err stays 0.
- Assert rst_n=0 mid-WRITE → memory all 0x00, state_q=0 immediately; a latch edge after release enters ADDR.

Source files
------------

// File: rtl/subneg_mem_responder_if.sv
// SUBNEG external SRAM bus: latch/OE/WE/out strobes plus data, shared by initiator and responder.
// Latency: n/a (wires only).
// Backpressure: none; the initiator paces every transfer with its strobes.
interface subneg_mem_responder_if;
    logic       bus_latch_clk;
    logic       bus_oe_n;
    logic       bus_we_n;
    logic       bus_out_clk;
    logic [7:0] bus_data_in;
    logic [7:0] bus_data_out;
    logic       bus_data_oe;

    modport master (
        output bus_latch_clk, bus_oe_n, bus_we_n, bus_out_clk, bus_data_in,
        input  bus_data_out, bus_data_oe
    );

    modport slave (
        input  bus_latch_clk, bus_oe_n, bus_we_n, bus_out_clk, bus_data_in,
        output bus_data_out, bus_data_oe
    );
endinterface

// File: rtl/subneg_mem_responder.sv
// SUBNEG memory responder: address latch + 2^ADDR_W x 8 SRAM + output latch; RESP_ERR_CHECK_EN adds sticky bus_err.
// Latency: strobe edges act at the clk edge that first sees them; read data is combinational from addr_q.
// Backpressure: none; host load (ld_en) owns the memory and masks all bus strobes.
module subneg_mem_responder #(
    parameter int ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    subneg_mem_responder_if.slave        bus,
    input  logic                         ld_en,
    input  logic [7:0]                   ld_addr,
    input  logic [7:0]                   ld_data,
    output logic [7:0]                   out_q,
    output logic                         out_valid,
    output logic                         bus_err,
    output logic [1:0]                   state_q
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_READ  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_mem [DEPTH];
    logic [7:0]        r_addr_q;
    logic [7:0]        r_out_q;
    logic              r_out_valid;
    logic              r_latch_d;
    logic              r_we_n_d;
    logic              r_out_clk_d;

    logic              w_latch_rise;
    logic              w_we_fall;
    logic              w_out_rise;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_addr_idx;
    logic [ADDR_W-1:0] w_ld_idx;

    assign w_latch_rise = bus.bus_latch_clk & ~r_latch_d;
    assign w_we_fall    = ~bus.bus_we_n & r_we_n_d;
    assign w_out_rise   = bus.bus_out_clk & ~r_out_clk_d;

    // addr_q keeps all 8 bits so addresses beyond the array read as 0 instead of aliasing
    assign w_in_range = ((r_addr_q >> ADDR_W) == 8'd0);
    assign w_addr_idx = ADDR_W'(r_addr_q);
    assign w_ld_idx   = ADDR_W'(ld_addr);

    assign bus.bus_data_oe  = ~bus.bus_oe_n & ~ld_en;
    assign bus.bus_data_out = w_in_range ? r_mem[w_addr_idx] : 8'h00;

    assign out_q     = r_out_q;
    assign out_valid = r_out_valid;
    assign state_q   = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latch_d   <= 1'b0;
            r_we_n_d    <= 1'b1;
            r_out_clk_d <= 1'b0;
        end else begin
            r_latch_d   <= bus.bus_latch_clk;
            r_we_n_d    <= bus.bus_we_n;
            r_out_clk_d <= bus.bus_out_clk;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ld_en) begin
            w_state_nxt = S_IDLE;
        end else if (w_latch_rise) begin
            w_state_nxt = S_ADDR;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (!bus.bus_oe_n)  w_state_nxt = S_READ;
                    else if (w_we_fall) w_state_nxt = S_WRITE;
                end
                S_READ:  if (bus.bus_oe_n) w_state_nxt = S_ADDR;
                S_WRITE: if (bus.bus_we_n) w_state_nxt = S_ADDR;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr_q    <= 8'h00;
            r_out_q     <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_rise & ~ld_en;
            if (w_latch_rise && !ld_en) r_addr_q <= bus.bus_data_in;
            if (w_out_rise && !ld_en)   r_out_q  <= bus.bus_data_in;
        end
    end

    // The write uses addr_q as it stood before this edge, so a coincident latch edge cannot redirect it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
        end else if (ld_en) begin
            r_mem[w_ld_idx] <= ld_data;
        end else if (w_we_fall && w_in_range) begin
            r_mem[w_addr_idx] <= bus.bus_data_in;
        end
    end

`ifdef RESP_ERR_CHECK_EN
    logic r_oe_n_d;
    logic r_bus_err;
    logic w_oe_fall;
    logic w_err_evt;

    assign w_oe_fall = ~bus.bus_oe_n & r_oe_n_d;
    assign w_err_evt = ~ld_en & ((~bus.bus_oe_n & ~bus.bus_we_n) |
                                 ((r_state == S_IDLE) & (w_oe_fall | w_we_fall)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oe_n_d  <= 1'b1;
            r_bus_err <= 1'b0;
        end else begin
            r_oe_n_d  <= bus.bus_oe_n;
            r_bus_err <= r_bus_err | w_err_evt;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif
endmodule

// File: tb/tb_subneg_mem_responder.sv
// Randomised and directed bench for subneg_mem_responder against a behavioural memory/bus model.
module tb_subneg_mem_responder;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef RESP_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] out_q;
    logic       out_valid;
    logic       bus_err;
    logic [1:0] state_q;

    subneg_mem_responder_if bus();

    subneg_mem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .out_q     (out_q),
        .out_valid (out_valid),
        .bus_err   (bus_err),
        .state_q   (state_q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: byte array plus the previous strobe levels seen by the responder
    logic [7:0] m_mem [256];
    logic [7:0] m_addr;
    logic [7:0] m_outq;
    bit         m_outvld;
    bit         m_err;
    int         m_state;
    bit         p_latch, p_oe_n, p_we_n, p_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_addr = 8'h00; m_outq = 8'h00; m_outvld = 0; m_err = 0; m_state = 0;
        p_latch = 0; p_oe_n = 1; p_we_n = 1; p_out = 0;
    endtask

    task automatic model_clock();
        bit lr, of, wf, orr;
        lr  = bus.bus_latch_clk && !p_latch;
        of  = !bus.bus_oe_n && p_oe_n;
        wf  = !bus.bus_we_n && p_we_n;
        orr = bus.bus_out_clk && !p_out;
        if (ld_en) begin
            m_mem[ld_addr % DEPTH] = ld_data;
            m_state  = 0;
            m_outvld = 0;
        end else begin
            if (wf && m_addr < DEPTH) m_mem[m_addr] = bus.bus_data_in;
            if (ERR_EN && ((!bus.bus_oe_n && !bus.bus_we_n) || (m_state == 0 && (of || wf))))
                m_err = 1;
            m_outvld = orr;
            if (orr) m_outq = bus.bus_data_in;
            if (lr) m_state = 1;
            else if (m_state == 1 && !bus.bus_oe_n) m_state = 2;
            else if (m_state == 1 && wf) m_state = 3;
            else if (m_state == 2 && bus.bus_oe_n) m_state = 1;
            else if (m_state == 3 && bus.bus_we_n) m_state = 1;
            if (lr) m_addr = bus.bus_data_in;
        end
        p_latch = bus.bus_latch_clk; p_oe_n = bus.bus_oe_n;
        p_we_n  = bus.bus_we_n;      p_out  = bus.bus_out_clk;
    endtask

    task automatic check_all();
        chk("data_oe", bus.bus_data_oe, !bus.bus_oe_n && !ld_en);
        chk("data_out", bus.bus_data_out, (m_addr < DEPTH) ? m_mem[m_addr] : 8'h00);
        chk("out_q", out_q, m_outq);
        chk("out_valid", out_valid, m_outvld);
        chk("bus_err", bus_err, m_err);
        chk("state", state_q, m_state);
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_idle();
        bus.bus_latch_clk = 0; bus.bus_oe_n = 1; bus.bus_we_n = 1; bus.bus_out_clk = 0;
        ld_en = 0;
    endtask

    task automatic latch_addr(input logic [7:0] a);
        bus.bus_data_in = a; bus.bus_latch_clk = 1; step();
        bus.bus_latch_clk = 0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        ld_en = 1; ld_addr = a; ld_data = d; step();
        ld_en = 0;
    endtask

    initial begin
        rst_n = 0;
        set_idle();
        ld_addr = 0; ld_data = 0; bus.bus_data_in = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_state", state_q, 0);
        chk("rst_outq", out_q, 0);
        rst_n = 1;
        step();

        // Preload then read through the bus
        preload(8'h03, 8'h5A);
        latch_addr(8'h03);
        bus.bus_oe_n = 0; step();
        chk("rd_oe", bus.bus_data_oe, 1);
        chk("rd_5a", bus.bus_data_out, 8'h5A);
        chk("rd_state", state_q, 2);
        bus.bus_oe_n = 1; step();

        // Long WE low: only the first cycle's data may land
        latch_addr(8'h07);
        bus.bus_data_in = 8'h21; bus.bus_we_n = 0; step();
        chk("wr_state", state_q, 3);
        bus.bus_data_in = 8'h33; step(); step();
        bus.bus_we_n = 1; step();
        latch_addr(8'h07);
        bus.bus_oe_n = 0; step();
        chk("wr_once", bus.bus_data_out, 8'h21);
        bus.bus_oe_n = 1; step();

        // Out-of-range address; preload address 0x20 wraps to mem[0]
        preload(8'h20, 8'h11);
        latch_addr(8'h40);
        bus.bus_oe_n = 0; step();
        chk("oor_rd", bus.bus_data_out, 8'h00);
        bus.bus_oe_n = 1; bus.bus_data_in = 8'h99; bus.bus_we_n = 0; step();
        bus.bus_we_n = 1; step();
        latch_addr(8'h00);
        bus.bus_oe_n = 0; step();
        chk("oor_mem0", bus.bus_data_out, 8'h11);
        bus.bus_oe_n = 1; step();

        // Output port capture and one-cycle valid
        bus.bus_data_in = 8'hC3; bus.bus_out_clk = 1; step();
        chk("outq_c3", out_q, 8'hC3);
        chk("outvld_hi", out_valid, 1);
        step();
        chk("outvld_lo", out_valid, 0);
        bus.bus_out_clk = 0; step();

        // OE and WE together
        latch_addr(8'h05);
        bus.bus_oe_n = 0; bus.bus_we_n = 0; step();
        chk("err_set", bus_err, ERR_EN);
        bus.bus_oe_n = 1; bus.bus_we_n = 1; step(); step();
        chk("err_hold", bus_err, ERR_EN);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            bus.bus_latch_clk = ($urandom_range(0, 3) == 0);
            bus.bus_oe_n      = ($urandom_range(0, 2) != 0);
            bus.bus_we_n      = ($urandom_range(0, 2) != 0);
            bus.bus_out_clk   = ($urandom_range(0, 3) == 0);
            bus.bus_data_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, DEPTH - 1));
            ld_en             = ($urandom_range(0, 15) == 0);
            ld_addr           = 8'($urandom);
            ld_data           = 8'($urandom);
            step();
        end
        set_idle(); step();

        // Reset in the middle of a write
        latch_addr(8'h09);
        bus.bus_data_in = 8'h77; bus.bus_we_n = 0; step();
        chk("mid_wr_state", state_q, 3);
        #2 rst_n = 0;
        #1 model_reset();
        chk("arst_state", state_q, 0);
        chk("arst_outq", out_q, 0);
        chk("arst_err", bus_err, 0);
        @(negedge clk);
        set_idle();
        @(negedge clk);
        rst_n = 1;
        for (int a = 0; a < DEPTH; a++) begin
            latch_addr(8'(a));
            bus.bus_oe_n = 0; step();
            chk("arst_mem", bus.bus_data_out, 8'h00);
            bus.bus_oe_n = 1;
        end
        step();
        latch_addr(8'h04);
        chk("post_rst_addr", state_q, 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
